// File: rtl/audio_pwm_out_pkg.sv
// Shared constants for the audio output path: FSM encodings, midscale level, default divider.
package audio_pwm_out_pkg;
  localparam logic [1:0] ST_MUTE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam logic [15:0] MIDSCALE        = 16'h8000;
  localparam int          DEFAULT_CLK_DIV = 3200;

  // Signed two's-complement to unsigned offset-binary.
  function automatic logic [15:0] to_offset(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction
endpackage

// File: rtl/audio_pwm_out_sample_fifo.sv
// Sample FIFO: pushes at full and pops at empty are ignored; flush empties it in one cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample FIFO, MUTE/FILL/PLAY control, tick divider and 8-bit PWM modulator.
// Define AUDIO_OUT_SIGMA_DELTA_EN to replace the PWM with a first-order sigma-delta modulator.
module audio_pwm_out
  import audio_pwm_out_pkg::*;
#(
  parameter int  CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  PRIME_LEVEL = 4,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [15:0]   sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          sample_tick,
  output logic          audio_pwm,
  output logic          audio_sd,
  output logic          underrun,
  output logic [LW-1:0] fifo_level
);
  localparam int         DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] TICK_AT  = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] PRIME_LV = LW'(PRIME_LEVEL);

  logic [DW-1:0] div_cnt;
  logic [1:0]    state;
  logic [15:0]   hold;
  logic [15:0]   pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          playing;
  logic          do_pop;
  logic          underrun_hit;

  assign sample_tick  = (div_cnt == TICK_AT);
  assign sample_ready = !fifo_full;
  assign audio_sd     = (state == ST_PLAY);
  // A tick with enable already low belongs to the flush, not to playback.
  assign playing      = (state == ST_PLAY) && enable;
  assign do_pop       = sample_tick && playing && !fifo_empty;
  assign underrun_hit = sample_tick && playing && fifo_empty;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (!enable),
    .push      (sample_valid && sample_ready),
    .push_data (sample_in),
    .pop       (do_pop),
    .pop_data  (pop_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              div_cnt <= '0;
    else if (sample_tick) div_cnt <= '0;
    else                  div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_MUTE;
    end else if (!enable) begin
      state <= ST_MUTE;
    end else begin
      case (state)
        ST_MUTE: state <= ST_FILL;
        ST_FILL: if (fifo_level >= PRIME_LV) state <= ST_PLAY;
        ST_PLAY: if (underrun_hit) state <= ST_FILL;
        default: state <= ST_MUTE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= MIDSCALE;
      underrun <= 1'b0;
    end else begin
      underrun <= underrun_hit;
      if (!playing)          hold <= MIDSCALE;
      else if (do_pop)       hold <= to_offset(pop_data);
      else if (underrun_hit) hold <= MIDSCALE;
    end
  end

`ifdef AUDIO_OUT_SIGMA_DELTA_EN
  logic [16:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[15:0]} + {1'b0, hold};
  end

  assign audio_pwm = acc[16];
`else
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt   <= '0;
      audio_pwm <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 8'd1;
      audio_pwm <= (pwm_cnt < hold[15:8]);
    end
  end
`endif
endmodule
